lsu_mem: RTL
============

# lsu_mem

MEM-stage load/store unit of the NPC pipeline. Consumes the EX/MEM-registered outputs of the execute stage: ALU result as address, forwarded store data, and memory control. Runs one valid/ready data-memory transaction per memory instruction. Stalls the pipeline until the access completes and returns an aligned, sign- or zero-extended load value for writeback.

## Interface
- No parameters; data and address width fixed at 32.
- Reset: one clock, `clk`; reset `rst` is asynchronous, active-high.
- `clk` in 1 — clock.
- `rst` in 1 — async active-high reset.
- `mem_valid` in 1 — a valid instruction occupies MEM.
- `mem_alu_result` in 32 — effective byte address.
- `mem_store_data` in 32 — store source (rs2); low bytes used.
- `mem_mem_wen` in 1 — store.
- `mem_mem_ren` in 1 — load.
- `mem_mem_type` in 3 — 0 = byte, 1 = half, 2 = word; 3–7 are treated as word.
- `mem_mem_unsigned` in 1 — zero-extend loads (LBU/LHU).
- `dmem_req_valid` out 1 — request valid.
- `dmem_req_ready` in 1 — memory accepts request.
- `dmem_req_addr` out 32 — word-aligned address ({addr[31:2],2'b00}).
- `dmem_req_wen` out 1 — 1 = write.
- `dmem_req_wdata` out 32 — lane-replicated write data.
- `dmem_req_wmask` out 4 — byte strobes.
- `dmem_resp_valid` in 1 — response/ack, one cycle per accepted request (reads and writes).
- `dmem_resp_rdata` in 32 — read word.
- `lsu_stall` out 1 — freeze IF..MEM this cycle.
- `lsu_done` out 1 — one-cycle pulse; access finished.
- `load_data` out 32 — formatted load result, held until next done.
- `lsu_misaligned` out 1 — one-cycle pulse with `lsu_done`; access was misaligned.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- `start` = `mem_valid & (mem_mem_ren | mem_mem_wen)`.
- When both ren and wen are set, the access is a write.
- IDLE → REQ when `start` and aligned. Latch address, write flag, type, unsigned flag; compute wdata/wmask at latch.
- IDLE → DONE when `start` and misaligned: half with addr[0]=1, or word with addr[1:0]≠0. No bus request is issued. `lsu_misaligned` is set, and `load_data` is left unchanged.
- REQ: `dmem_req_valid` = 1; addr/wen/wdata/wmask held stable until `dmem_req_ready`.
  - On ready with `dmem_resp_valid` in the same cycle → DONE.
  - On ready without it → WAIT.
- WAIT: on `dmem_resp_valid` → DONE; otherwise remain in WAIT.
- DONE: `lsu_done` = 1 for exactly one cycle, then → IDLE unconditionally. `start` is not evaluated in DONE.
- Response capture: for loads, `load_data` is updated at the cycle the response is taken. For stores, `load_data` is unchanged.
- Write formatting:
  - Byte: wmask = 4'b0001 << addr[1:0]; wdata = {4{sd[7:0]}}.
  - Half: wmask = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{sd[15:0]}}.
  - Word: wmask = 4'b1111; wdata = sd.
- Read formatting: shifted = rdata >> {addr[1:0],3'b000}.
  - Byte: sign- or zero-extend shifted[7:0].
  - Half: sign- or zero-extend shifted[15:0].
  - Word: rdata.
- For reads, `dmem_req_wmask` = 0 and `dmem_req_wdata` = 0.
- `dmem_resp_valid` is ignored in IDLE, REQ-before-ready, and DONE; stale responses are dropped.

## Timing
- `lsu_stall` is combinational: (IDLE & `start`) | REQ | WAIT. It is 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- Minimum latency, ready and resp in the same cycle as request: IDLE → REQ → DONE. `lsu_done` is high 2 cycles after `start` is seen.
- Misaligned access: `lsu_done` and `lsu_misaligned` are high 1 cycle after `start`.
- Each extra wait cycle on ready or resp adds exactly one stall cycle.
- Reset values: state IDLE; `dmem_req_valid`, `dmem_req_wen`, `lsu_done`, `lsu_misaligned` = 0; `dmem_req_addr`, `dmem_req_wdata`, `load_data` = 0; `dmem_req_wmask` = 0.
- Reset asserted mid-transaction aborts it: outputs return to reset values, and any later response is ignored.
- Back-to-back memory instructions: the second one is sampled in IDLE on the cycle after DONE.

## Test plan
- LW addr 0x8000_0004, ready and resp immediate, rdata 0xDEAD_BEEF → req addr 0x8000_0004, wmask 0; `lsu_done` at cycle 2; `load_data` = 0xDEAD_BEEF; stall high for 2 cycles.
- LB addr 0x...03, rdata 0x80AA_BBCC → `load_data` 0xFFFF_FF80. The same access as LBU → 0x0000_0080.
- SH addr 0x...02, sd 0x1234_5678, ready delayed 3 cycles, resp 2 cycles after ready → wdata 0x5678_5678 and wmask 4'b1100, held stable throughout; `lsu_done` after 7 cycles; `load_data` unchanged.
- LW addr 0x...01 → no `dmem_req_valid`; `lsu_done` and `lsu_misaligned` pulse at cycle 1; stall for 1 cycle.
- `rst` asserted in WAIT, followed by a late `dmem_resp_valid` → outputs at reset values, state IDLE, response ignored, no `lsu_done`.
- SB then LW back-to-back with `mem_valid` held → two distinct transactions, DONE separating them; a stray resp in DONE is ignored.

Source files
------------

// File: rtl/lsu_mem.sv
// lsu_mem: MEM-stage load/store unit running one valid/ready data-memory transaction per memory instruction.
//   clk, rst                      clock, async active-high reset
//   mem_valid, mem_alu_result     instruction present in MEM, effective byte address
//   mem_store_data                store source; low bytes replicated into lanes
//   mem_mem_wen/ren/type/unsigned memory control (type 0 byte, 1 half, else word)
//   dmem_req_*                    request channel, held stable until ready
//   dmem_resp_valid/rdata         one response per accepted request
//   lsu_stall                     freeze IF..MEM this cycle
//   lsu_done, lsu_misaligned      one-cycle completion pulses
//   load_data                     formatted load result, held until the next load completes
module lsu_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_store_data,
  input  logic        mem_mem_wen,
  input  logic        mem_mem_ren,
  input  logic [2:0]  mem_mem_type,
  input  logic        mem_mem_unsigned,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_req_addr,
  output logic        dmem_req_wen,
  output logic [31:0] dmem_req_wdata,
  output logic [3:0]  dmem_req_wmask,
  input  logic        dmem_resp_valid,
  input  logic [31:0] dmem_resp_rdata,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic [31:0] load_data,
  output logic        lsu_misaligned
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_load;
  logic [3:0]  r_wmask;
  logic [1:0]  r_off, r_size;
  logic        r_uns, r_wen, r_mis;
  logic        w_start, w_byte, w_half, w_mis, w_take;
  logic [31:0] w_wdata, w_fmt;
  logic [3:0]  w_wmask;
  logic [15:0] w_shift;
  assign w_start = mem_valid & (mem_mem_ren | mem_mem_wen);
  assign w_byte  = mem_mem_type == 3'd0;
  assign w_half  = mem_mem_type == 3'd1;
  assign w_mis   = (w_half & mem_alu_result[0]) | (~w_byte & ~w_half & |mem_alu_result[1:0]);
  // A write wins when both ren and wen are set; reads carry no data and no strobes.
  assign w_wmask = ~mem_mem_wen ? 4'b0000 :
                   w_byte ? 4'b0001 << mem_alu_result[1:0] :
                   w_half ? (mem_alu_result[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wdata = ~mem_mem_wen ? 32'd0 :
                   w_byte ? {4{mem_store_data[7:0]}} :
                   w_half ? {2{mem_store_data[15:0]}} : mem_store_data;
  // Responses only count once the request has been accepted; anything else is stale.
  assign w_take  = (r_state == S_REQ && dmem_req_ready && dmem_resp_valid) ||
                   (r_state == S_WAIT && dmem_resp_valid);
  assign w_shift = 16'(dmem_resp_rdata >> {r_off, 3'b000});
  assign w_fmt   = r_size == 2'd0 ? {{24{~r_uns & w_shift[7]}}, w_shift[7:0]} :
                   r_size == 2'd1 ? {{16{~r_uns & w_shift[15]}}, w_shift[15:0]} : dmem_resp_rdata;
  always_comb begin
    w_next         = r_state;
    dmem_req_valid = 1'b0;
    lsu_stall      = 1'b0;
    lsu_done       = 1'b0;
    lsu_misaligned = 1'b0;
    case (r_state)
      S_IDLE: begin
        lsu_stall = w_start;
        if (w_start) w_next = w_mis ? S_DONE : S_REQ;
      end
      S_REQ: begin
        dmem_req_valid = 1'b1;
        lsu_stall      = 1'b1;
        if (dmem_req_ready) w_next = dmem_resp_valid ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        lsu_stall = 1'b1;
        if (dmem_resp_valid) w_next = S_DONE;
      end
      default: begin
        lsu_done       = 1'b1;
        lsu_misaligned = r_mis;
        w_next         = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wmask <= 4'd0;
      r_load  <= 32'd0;
      r_off   <= 2'd0;
      r_size  <= 2'd0;
      r_uns   <= 1'b0;
      r_wen   <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_start) begin
        r_mis <= w_mis;
        if (!w_mis) begin
          r_addr  <= {mem_alu_result[31:2], 2'b00};
          r_off   <= mem_alu_result[1:0];
          r_size  <= {~w_byte & ~w_half, w_half};
          r_uns   <= mem_mem_unsigned;
          r_wen   <= mem_mem_wen;
          r_wdata <= w_wdata;
          r_wmask <= w_wmask;
        end
      end
      if (w_take && !r_wen) r_load <= w_fmt;
    end
  end
  assign dmem_req_addr  = r_addr;
  assign dmem_req_wen   = r_wen;
  assign dmem_req_wdata = r_wdata;
  assign dmem_req_wmask = r_wmask;
  assign load_data      = r_load;
endmodule
